// File: rtl/fact_pkg.sv
// Shared constants and types for the factorial BCD readout converter.
// Optional build macro used by the converter: FACT_BCD_BLANK_EN.
package fact_pkg;

  localparam int FACT_WIDTH  = 32;
  localparam int FACT_DIGITS = 10;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fact_bcd_conv_if.sv
// Handshake bundle between the factorial stage, the BCD converter and the readout.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface fact_bcd_conv_if #(
    parameter int WIDTH  = fact_pkg::FACT_WIDTH,
    parameter int DIGITS = fact_pkg::FACT_DIGITS
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      bin_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic [3:0]            ndigits;
    fact_pkg::state_t      dbg_state;

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, ndigits, dbg_state
    );

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, ndigits, dbg_state
    );
endinterface

// File: rtl/bcd_add3.sv
// One BCD digit correction cell for the shift-and-add-3 converter.
module bcd_add3 (
    input  logic [3:0] i_d,
    output logic [3:0] o_d
);
    assign o_d = (i_d >= 4'd5) ? (i_d + 4'd3) : i_d;
endmodule

// File: rtl/fact_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3) for the factorial result.
// Define FACT_BCD_BLANK_EN to drive leading-zero digits as the display blank code.
module fact_bcd_conv
    import fact_pkg::*;
#(
    parameter int WIDTH  = FACT_WIDTH,
    parameter int DIGITS = FACT_DIGITS
) (
    input  logic            clk,
    input  logic            reset,
    fact_bcd_conv_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int BCD_W = 4 * DIGITS;

    state_t             r_state;
    logic [WIDTH-1:0]   r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   r_bcd_out;
    logic [CNT_W-1:0]   r_cnt;
    logic [3:0]         r_ndig;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [BCD_W-1:0]       w_adj;
    logic [BCD_W+WIDTH-1:0] w_shift;
    logic [BCD_W-1:0]       w_next_bcd;
    logic [WIDTH-1:0]       w_next_bin;
    logic [BCD_W-1:0]       w_disp;
    logic [3:0]             w_ndig;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_d (r_bcd[4*g +: 4]),
            .o_d (w_adj[4*g +: 4])
        );
    end

    // Accumulator and binary word shift as one long register.
    assign w_shift    = {w_adj, r_bin} << 1;
    assign w_next_bcd = w_shift[BCD_W+WIDTH-1:WIDTH];
    assign w_next_bin = w_shift[WIDTH-1:0];

    always_comb begin
        w_ndig = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_next_bcd[4*i +: 4] != 4'd0) w_ndig = 4'(i + 1);
        end
    end

`ifdef FACT_BCD_BLANK_EN
    always_comb begin
        w_disp = w_next_bcd;
        for (int i = 1; i < DIGITS; i++) begin
            if (i >= int'(w_ndig)) w_disp[4*i +: 4] = BCD_BLANK;
        end
    end
`else
    assign w_disp = w_next_bcd;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_bcd_out   <= '0;
            r_cnt       <= '0;
            r_ndig      <= 4'd1;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_bin      <= bus.bin_in;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bin <= w_next_bin;
                    r_bcd <= w_next_bcd;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_bcd_out   <= w_disp;
                        r_ndig      <= w_ndig;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // A pending in_valid is not looked at here; the accept waits for IDLE.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.bcd_out   = r_bcd_out;
    assign bus.ndigits   = r_ndig;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_fact_bcd_conv.sv
// Bench for fact_bcd_conv: randomized conversions against a decimal reference model.
// Build with FACT_BCD_BLANK_EN defined to check the blanked output variant.
module tb_fact_bcd_conv;
  import fact_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  logic [43:0] exp_q[$];

  fact_bcd_conv_if bus ();

  fact_bcd_conv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by repeated division, packed as {ndigits, bcd}.
  function automatic logic [43:0] ref_model(input logic [31:0] v);
    logic [39:0] bcd;
    logic [3:0]  nd;
    longint      x;
    int          d;
    x   = longint'(v);
    bcd = '0;
    nd  = 4'd1;
    for (int i = 0; i < 10; i++) begin
      d = int'(x % 10);
      x = x / 10;
      bcd[4*i +: 4] = 4'(d);
      if (d != 0) nd = 4'(i + 1);
    end
`ifdef FACT_BCD_BLANK_EN
    for (int i = 1; i < 10; i++) begin
      if (i >= int'(nd)) bcd[4*i +: 4] = 4'hF;
    end
`endif
    return {nd, bcd};
  endfunction

  // Full transaction: accept, latency, result, hold under back-pressure, release.
  task automatic convert(input logic [31:0] v, input int hold, input bit pulse, input bit overlap);
    int          n;
    int          cyc;
    logic [43:0] exp;
    @(negedge clk);
    bus.bin_in   = v;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_ready", 64'(bus.in_ready), 64'(1));
    exp_q.push_back(ref_model(v));
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("busy_in_ready", 64'(bus.in_ready), 64'(0));
    cyc = 0;
    while (!bus.out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (pulse && cyc == 5) begin
        bus.bin_in   = 32'd720;
        bus.in_valid = 1'b1;
      end
      if (pulse && cyc == 7) bus.in_valid = 1'b0;
    end
    check_eq("latency", 64'(cyc), 64'(32));
    exp = exp_q.pop_front();
    check_eq("bcd_out", 64'(bus.bcd_out), 64'(exp[39:0]));
    check_eq("ndigits", 64'(bus.ndigits), 64'(exp[43:40]));
    check_eq("done_in_ready", 64'(bus.in_ready), 64'(0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 64'(bus.out_valid), 64'(1));
      check_eq("hold_bcd", 64'(bus.bcd_out), 64'(exp[39:0]));
      check_eq("hold_in_ready", 64'(bus.in_ready), 64'(0));
    end
    bus.out_ready = 1'b1;
    if (overlap) begin
      bus.bin_in   = 32'd99;
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check_eq("post_valid", 64'(bus.out_valid), 64'(0));
    check_eq("post_in_ready", 64'(bus.in_ready), 64'(1));
    check_eq("post_bcd_kept", 64'(bus.bcd_out), 64'(exp[39:0]));
    if (pulse || overlap) begin
      repeat (3) @(negedge clk);
      check_eq("no_extra_accept", 64'(bus.in_ready), 64'(1));
    end
  endtask

  initial begin
    logic [31:0] fact;
    int          cyc;
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.bin_in    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check_eq("rst_bcd", 64'(bus.bcd_out), 64'(0));
    check_eq("rst_ndigits", 64'(bus.ndigits), 64'(1));
    check_eq("rst_state", 64'(bus.dbg_state), 64'(IDLE));
    reset = 1'b1;
    @(negedge clk);

    convert(32'd0, 0, 1'b0, 1'b0);
    convert(32'd3628800, 0, 1'b0, 1'b0);
    convert(32'hFFFF_FFFF, 1, 1'b0, 1'b0);
    convert(32'd24, 5, 1'b0, 1'b0);
    convert(32'd120, 0, 1'b1, 1'b0);
    convert(32'd7, 2, 1'b0, 1'b1);

    // factorials 1!..12! as produced upstream
    fact = 32'd1;
    for (int k = 1; k <= 12; k++) begin
      fact = fact * 32'(k);
      convert(fact, $urandom_range(0, 2), 1'b0, 1'b0);
    end

    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 2))
        0:       convert($urandom_range(0, 999), $urandom_range(0, 3), 1'b0, 1'b0);
        1:       convert($urandom_range(0, 9_999_999), $urandom_range(0, 3), 1'b0, $urandom_range(0, 1) == 1);
        default: convert($urandom, $urandom_range(0, 3), $urandom_range(0, 1) == 1, 1'b0);
      endcase
    end

    // reset in the middle of SHIFT discards the in-flight word
    @(negedge clk);
    bus.bin_in   = 32'd123456;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("mid_state", 64'(bus.dbg_state), 64'(SHIFT));
    reset = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(bus.out_valid), 64'(0));
    check_eq("mid_rst_in_ready", 64'(bus.in_ready), 64'(1));
    check_eq("mid_rst_ndigits", 64'(bus.ndigits), 64'(1));
    check_eq("mid_rst_bcd", 64'(bus.bcd_out), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) cyc++;
    end
    check_eq("mid_rst_no_result", 64'(cyc), 64'(0));
    convert(32'd5, 0, 1'b0, 1'b0);

    check_eq("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
